// File: rtl/spi_accel_pkg.sv
// Shared types, frame constants and sample decoding for the accelerometer poller.
package spi_accel_pkg;

    typedef enum logic [2:0] {IDLE, INIT, ISSUE, WAIT, GAP, PERIOD_WAIT} state_e;
    typedef enum logic [1:0] {AXIS_X, AXIS_Y, AXIS_Z} axis_e;

    localparam logic [7:0] CMD_READ          = 8'h0B;
    localparam logic [7:0] CMD_WRITE         = 8'h0A;
    localparam logic [7:0] ADDR_XDATA_L      = 8'h0E;
    localparam logic [7:0] ADDR_YDATA_L      = 8'h10;
    localparam logic [7:0] ADDR_ZDATA_L      = 8'h12;
    localparam logic [7:0] ADDR_POWER_CTL    = 8'h2D;
    localparam logic [7:0] POWER_CTL_MEASURE = 8'h02;
    localparam logic [2:0] READ_BYTES        = 3'd4;
    localparam logic [2:0] INIT_BYTES        = 3'd3;

    function automatic logic [7:0] axis_addr(input axis_e axis);
        case (axis)
            AXIS_Y:  return ADDR_YDATA_L;
            AXIS_Z:  return ADDR_ZDATA_L;
            default: return ADDR_XDATA_L;
        endcase
    endfunction

    // Byte 3 holds data[7:0]; the low nibble of byte 4 holds data[11:8] incl. the sign.
    function automatic logic [15:0] decode_sample(input logic [31:0] rd);
        logic [11:0] raw;
        raw = {rd[3:0], rd[15:8]};
        return {{4{raw[11]}}, raw};
    endfunction

endpackage

// File: rtl/spi_accel_poller_level_sync.sv
// Two-flop synchroniser for the master's read fill level; a level counts only
// once both stages agree.
module spi_level_sync (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [2:0] level_i,
    output logic [2:0] level_o,
    output logic       stable_o
);

    logic [2:0] s1_q;
    logic [2:0] s2_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= level_i;
            s2_q <= s1_q;
        end
    end

    assign level_o  = s2_q;
    assign stable_o = (s1_q == s2_q);

endmodule

// File: rtl/spi_accel_poller.sv
// Periodic X/Y/Z sample poller for an ADXL362-style accelerometer behind an SPI master.
// Define ACCEL_INIT_EN to write POWER_CTL=measurement once after reset before polling.
module spi_accel_poller
    import spi_accel_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES  = 100000,
    parameter int unsigned GAP_CYCLES     = 64,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        clear_err_i,
    output logic        spi_enable_o,
    output logic [31:0] spi_write_data_o,
    output logic [2:0]  spi_write_bytes_o,
    input  logic [31:0] spi_read_data_i,
    input  logic [2:0]  spi_read_bytes_i,
    output logic [15:0] x_o,
    output logic [15:0] y_o,
    output logic [15:0] z_o,
    output logic        sample_valid_o,
    output logic        busy_o,
    output logic        timeout_err_o
);

`ifdef ACCEL_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    localparam logic [31:0] PER_LAST = 32'(PERIOD_CYCLES - 1);
    localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_e      state_q;
    axis_e       axis_q;
    logic [31:0] per_q, tmo_q, gap_q;
    logic        per_done_q;
    logic        armed_q, abort_q, init_xfer_q, init_done_q;
    logic        spi_en_q;
    logic [31:0] spi_wdata_q;
    logic [2:0]  spi_wbytes_q;
    logic [15:0] stg_x_q, stg_y_q, stg_z_q;
    logic [15:0] x_q, y_q, z_q;
    logic        sample_valid_q, err_q;

    logic [2:0]  lvl;
    logic        lvl_stable;
    logic [2:0]  target_lvl;
    logic        at_target;
    logic        per_hit;

    spi_level_sync u_level_sync (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .level_i  (spi_read_bytes_i),
        .level_o  (lvl),
        .stable_o (lvl_stable)
    );

    assign target_lvl = init_xfer_q ? INIT_BYTES : READ_BYTES;
    assign at_target  = lvl_stable && (lvl == target_lvl);
    // The period may already have run out while the transactions were still going.
    assign per_hit    = per_done_q || (per_q == PER_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            axis_q         <= AXIS_X;
            per_q          <= '0;
            per_done_q     <= 1'b0;
            tmo_q          <= '0;
            gap_q          <= '0;
            armed_q        <= 1'b0;
            abort_q        <= 1'b0;
            init_xfer_q    <= 1'b0;
            init_done_q    <= 1'b0;
            spi_en_q       <= 1'b0;
            spi_wdata_q    <= '0;
            spi_wbytes_q   <= '0;
            stg_x_q        <= '0;
            stg_y_q        <= '0;
            stg_z_q        <= '0;
            x_q            <= '0;
            y_q            <= '0;
            z_q            <= '0;
            sample_valid_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            sample_valid_q <= 1'b0;
            per_q          <= per_q + 32'd1;
            if (per_q == PER_LAST) per_done_q <= 1'b1;
            if (clear_err_i) err_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (INIT_EN && !init_done_q) begin
                        state_q <= INIT;
                    end else if (enable_i) begin
                        axis_q     <= AXIS_X;
                        per_q      <= '0;
                        per_done_q <= 1'b0;
                        state_q    <= ISSUE;
                    end
                end
                INIT: begin
                    spi_wdata_q  <= {CMD_WRITE, ADDR_POWER_CTL, POWER_CTL_MEASURE, 8'h00};
                    spi_wbytes_q <= INIT_BYTES;
                    spi_en_q     <= 1'b1;
                    armed_q      <= 1'b0;
                    abort_q      <= 1'b0;
                    init_xfer_q  <= 1'b1;
                    tmo_q        <= '0;
                    state_q      <= WAIT;
                end
                ISSUE: begin
                    spi_wdata_q  <= {CMD_READ, axis_addr(axis_q), 16'h0000};
                    spi_wbytes_q <= READ_BYTES;
                    spi_en_q     <= 1'b1;
                    armed_q      <= 1'b0;
                    abort_q      <= 1'b0;
                    init_xfer_q  <= 1'b0;
                    tmo_q        <= '0;
                    state_q      <= WAIT;
                end
                WAIT: begin
                    tmo_q <= tmo_q + 32'd1;
                    // A level left over from the previous frame must be seen to change first.
                    if (!at_target) armed_q <= 1'b1;
                    if (armed_q && at_target) begin
                        if (!init_xfer_q) begin
                            case (axis_q)
                                AXIS_Y:  stg_y_q <= decode_sample(spi_read_data_i);
                                AXIS_Z:  stg_z_q <= decode_sample(spi_read_data_i);
                                default: stg_x_q <= decode_sample(spi_read_data_i);
                            endcase
                        end
                        spi_en_q <= 1'b0;
                        gap_q    <= '0;
                        state_q  <= GAP;
                    end else if (tmo_q == TMO_LAST) begin
                        if (!clear_err_i) err_q <= 1'b1;
                        abort_q  <= 1'b1;
                        spi_en_q <= 1'b0;
                        gap_q    <= '0;
                        state_q  <= GAP;
                    end
                end
                GAP: begin
                    gap_q <= gap_q + 32'd1;
                    if (gap_q == GAP_LAST) begin
                        if (init_xfer_q) begin
                            if (!abort_q) init_done_q <= 1'b1;
                            state_q <= abort_q ? INIT : IDLE;
                        end else if (!abort_q && axis_q != AXIS_Z && enable_i) begin
                            axis_q  <= (axis_q == AXIS_X) ? AXIS_Y : AXIS_Z;
                            state_q <= ISSUE;
                        end else begin
                            if (!abort_q && axis_q == AXIS_Z) begin
                                x_q            <= stg_x_q;
                                y_q            <= stg_y_q;
                                z_q            <= stg_z_q;
                                sample_valid_q <= 1'b1;
                            end
                            if (!enable_i) begin
                                state_q <= IDLE;
                            end else if (per_hit) begin
                                axis_q     <= AXIS_X;
                                per_q      <= '0;
                                per_done_q <= 1'b0;
                                state_q    <= ISSUE;
                            end else begin
                                state_q <= PERIOD_WAIT;
                            end
                        end
                    end
                end
                PERIOD_WAIT: begin
                    if (!enable_i) begin
                        state_q <= IDLE;
                    end else if (per_hit) begin
                        axis_q     <= AXIS_X;
                        per_q      <= '0;
                        per_done_q <= 1'b0;
                        state_q    <= ISSUE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign spi_enable_o      = spi_en_q;
    assign spi_write_data_o  = spi_wdata_q;
    assign spi_write_bytes_o = spi_wbytes_q;
    assign x_o               = x_q;
    assign y_o               = y_q;
    assign z_o               = z_q;
    assign sample_valid_o    = sample_valid_q;
    assign timeout_err_o     = err_q;
    assign busy_o            = (state_q != IDLE) && (state_q != PERIOD_WAIT);

endmodule
